// File: rtl/tetris_pkg.sv
// Shared definitions for the falling-piece control path.
//   - state_t : sequencer FSM states
//   - move_t  : kind of proposed move; also the bit position of that move in
//               the one-hot pick vector produced by move_req_latch
//   - board size defaults used as parameter defaults by the sequencer
package tetris_pkg;

    localparam int BOARD_W_DEF = 10;
    localparam int BOARD_H_DEF = 20;
    localparam int NUM_MOVES   = 4;

    typedef enum logic [2:0] {
        WAIT_SPAWN = 3'd0,
        IDLE       = 3'd1,
        CHECK      = 3'd2,
        COMMIT     = 3'd3,
        LOCK       = 3'd4
    } state_t;

    // MV_DOWN covers both gravity tick and soft drop: both are y+1.
    typedef enum logic [1:0] {
        MV_DOWN  = 2'd0,
        MV_ROT   = 2'd1,
        MV_LEFT  = 2'd2,
        MV_RIGHT = 2'd3
    } move_t;

endpackage

// File: rtl/move_req_latch.sv
// Pending-request flags for the piece sequencer plus fixed-priority selection.
//
// Ports:
//   clock, reset : system clock, synchronous active-high reset
//   flush        : hold every flag clear and discard incoming pulses
//   clear        : the move currently on 'pick' has been taken; drop its flag(s)
//   tick, down, rot, left, right : one-cycle request pulses
//   pick         : one-hot (indexed by move_t) highest-priority pending move;
//                  all zero when nothing is pending
//
// Priority: tick/down > rot > left > right. A tick and a down pending together
// form one y+1 move, so taking MV_DOWN clears both flags.
module move_req_latch
    import tetris_pkg::*;
(
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 flush,
    input  logic                 clear,
    input  logic                 tick,
    input  logic                 down,
    input  logic                 rot,
    input  logic                 left,
    input  logic                 right,
    output logic [NUM_MOVES-1:0] pick
);

    logic tick_q;
    logic down_q;
    logic rot_q;
    logic left_q;
    logic right_q;

    logic clr_y;
    logic clr_rot;
    logic clr_left;
    logic clr_right;

    always_comb begin
        pick = '0;
        if (tick_q || down_q) begin
            pick[MV_DOWN] = 1'b1;
        end else if (rot_q) begin
            pick[MV_ROT] = 1'b1;
        end else if (left_q) begin
            pick[MV_LEFT] = 1'b1;
        end else if (right_q) begin
            pick[MV_RIGHT] = 1'b1;
        end
    end

    assign clr_y     = clear & pick[MV_DOWN];
    assign clr_rot   = clear & pick[MV_ROT];
    assign clr_left  = clear & pick[MV_LEFT];
    assign clr_right = clear & pick[MV_RIGHT];

    // The pulse is OR-ed in after the clear so a pulse landing in the same
    // cycle its flag is taken re-arms the flag instead of being lost. A pulse
    // while the flag is already set simply leaves it set (merged).
    always_ff @(posedge clock) begin
        if (reset || flush) begin
            tick_q  <= 1'b0;
            down_q  <= 1'b0;
            rot_q   <= 1'b0;
            left_q  <= 1'b0;
            right_q <= 1'b0;
        end else begin
            tick_q  <= (tick_q  & ~clr_y)     | tick;
            down_q  <= (down_q  & ~clr_y)     | down;
            rot_q   <= (rot_q   & ~clr_rot)   | rot;
            left_q  <= (left_q  & ~clr_left)  | left;
            right_q <= (right_q & ~clr_right) | right;
        end
    end

endmodule

// File: rtl/piece_move_sequencer.sv
// Falling-piece move sequencer. Serializes keyboard and gravity requests into
// one proposed placement at a time, hands it to the collision checker over a
// req/done handshake, commits accepted moves and raises lock when a y+1 move
// cannot be made.
//
// Ports:
//   clock, reset          : system clock, synchronous active-high reset
//   rot/left/right/down   : one-cycle keyboard request pulses
//   tick                  : one-cycle gravity pulse (y+1)
//   spawn                 : one-cycle pulse, load a new piece (WAIT_SPAWN only)
//   check_req             : proposal valid to the checker
//   prop_x/prop_y/prop_rot: proposed placement
//   check_done/check_ok   : checker result; only looked at in CHECK
//   piece_x/piece_y       : committed position
//   rotation              : committed rotation 0..3
//   lock                  : one-cycle pulse, piece landed
//   busy                  : state is not IDLE
//   state                 : current FSM state (observation only)
//
// Handshake: check_req rises when a proposal is formed and stays high, with
// prop_* unchanged, until the first cycle check_done is high. check_done may
// be high in the very first check_req cycle; it is ignored in any other state.
module piece_move_sequencer
    import tetris_pkg::*;
#(
    parameter int BOARD_W = BOARD_W_DEF,
    parameter int BOARD_H = BOARD_H_DEF,
    parameter int X_W     = 4,
    parameter int Y_W     = 5,
    parameter int SPAWN_X = 4,
    parameter int SPAWN_Y = 0
) (
    input  logic           clock,
    input  logic           reset,
    input  logic           rot,
    input  logic           left,
    input  logic           right,
    input  logic           down,
    input  logic           tick,
    input  logic           spawn,
    output logic           check_req,
    output logic [X_W-1:0] prop_x,
    output logic [Y_W-1:0] prop_y,
    output logic [1:0]     prop_rot,
    input  logic           check_done,
    input  logic           check_ok,
    output logic [X_W-1:0] piece_x,
    output logic [Y_W-1:0] piece_y,
    output logic [1:0]     rotation,
    output logic           lock,
    output logic           busy,
    output state_t         state
);

    localparam logic [X_W-1:0] X_LAST  = X_W'(BOARD_W - 1);
    localparam logic [Y_W-1:0] Y_LAST  = Y_W'(BOARD_H - 1);
    localparam logic [X_W-1:0] X_SPAWN = X_W'(SPAWN_X);
    localparam logic [Y_W-1:0] Y_SPAWN = Y_W'(SPAWN_Y);

    state_t               state_q;
    state_t               state_next;
    move_t                move_q;
    move_t                move_next;
    logic [NUM_MOVES-1:0] pick;
    logic                 flush;
    logic                 sel_clear;
    logic                 load_prop;
    logic                 do_spawn;
    logic                 do_commit;
    logic [X_W-1:0]       cand_x;
    logic [Y_W-1:0]       cand_y;
    logic [1:0]           cand_rot;

    // Requests are neither collected nor kept while no piece is in play.
    assign flush = (state_q == WAIT_SPAWN) || (state_q == LOCK);

    move_req_latch u_req_latch (
        .clock (clock),
        .reset (reset),
        .flush (flush),
        .clear (sel_clear),
        .tick  (tick),
        .down  (down),
        .rot   (rot),
        .left  (left),
        .right (right),
        .pick  (pick)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= WAIT_SPAWN;
        end else begin
            state_q <= state_next;
        end
    end

    always_comb begin
        state_next = state_q;
        move_next  = move_q;
        sel_clear  = 1'b0;
        load_prop  = 1'b0;
        do_spawn   = 1'b0;
        do_commit  = 1'b0;
        cand_x     = piece_x;
        cand_y     = piece_y;
        cand_rot   = rotation;
        check_req  = (state_q == CHECK);
        lock       = (state_q == LOCK);
        busy       = (state_q != IDLE);
        state      = state_q;

        unique case (state_q)
            WAIT_SPAWN: begin
                if (spawn) begin
                    do_spawn   = 1'b1;
                    state_next = IDLE;
                end
            end

            IDLE: begin
                if (|pick) begin
                    // Whatever is picked is consumed now, including moves that
                    // are rejected below without going to the checker.
                    sel_clear = 1'b1;
                    if (pick[MV_DOWN]) begin
                        move_next = MV_DOWN;
                        cand_y    = piece_y + 1'b1;
                        if (piece_y == Y_LAST) begin
                            state_next = LOCK;
                        end else begin
                            load_prop  = 1'b1;
                            state_next = CHECK;
                        end
                    end else if (pick[MV_ROT]) begin
                        move_next  = MV_ROT;
                        cand_rot   = rotation + 2'd1;
                        load_prop  = 1'b1;
                        state_next = CHECK;
                    end else if (pick[MV_LEFT]) begin
                        move_next = MV_LEFT;
                        cand_x    = piece_x - 1'b1;
                        if (piece_x != '0) begin
                            load_prop  = 1'b1;
                            state_next = CHECK;
                        end
                    end else begin
                        move_next = MV_RIGHT;
                        cand_x    = piece_x + 1'b1;
                        if (piece_x != X_LAST) begin
                            load_prop  = 1'b1;
                            state_next = CHECK;
                        end
                    end
                end
            end

            CHECK: begin
                if (check_done) begin
                    if (check_ok) begin
                        state_next = COMMIT;
                    end else if (move_q == MV_DOWN) begin
                        state_next = LOCK;
                    end else begin
                        state_next = IDLE;
                    end
                end
            end

            COMMIT: begin
                do_commit  = 1'b1;
                state_next = IDLE;
            end

            LOCK: begin
                state_next = WAIT_SPAWN;
            end

            default: begin
                state_next = WAIT_SPAWN;
            end
        endcase
    end

    // Proposal and committed placement. The proposal tracks the committed
    // values after reset/spawn so prop_* never shows stale data from an
    // earlier piece.
    always_ff @(posedge clock) begin
        if (reset || do_spawn) begin
            piece_x  <= X_SPAWN;
            piece_y  <= Y_SPAWN;
            rotation <= 2'd0;
            prop_x   <= X_SPAWN;
            prop_y   <= Y_SPAWN;
            prop_rot <= 2'd0;
            move_q   <= MV_DOWN;
        end else begin
            if (load_prop) begin
                prop_x   <= cand_x;
                prop_y   <= cand_y;
                prop_rot <= cand_rot;
                move_q   <= move_next;
            end
            if (do_commit) begin
                piece_x  <= prop_x;
                piece_y  <= prop_y;
                rotation <= prop_rot;
            end
        end
    end

endmodule

// File: doc/piece_move_sequencer.md
# piece_move_sequencer

Sequencer for the falling Tetris piece: collects keyboard move/rotate requests and the gravity tick and serializes them into one proposed move at a time. Each move goes to the collision checker over a req/done handshake. Accepted moves are committed to the piece position and rotation registers; a failed downward move raises a lock pulse. It sits between the keyboard decode/rotation request logic and the board/collision datapath, and it owns the piece's `x`, `y` and `rotation` state.

## Interface
Parameters:
- `BOARD_W`, 10, board width in cells
- `BOARD_H`, 20, board height in cells
- `X_W`, 4, width of the x coordinate
- `Y_W`, 5, width of the y coordinate
- `SPAWN_X`, 4, x value loaded on spawn
- `SPAWN_Y`, 0, y value loaded on spawn

Ports:
- `clock`  in  1  system clock; one clock domain
- `reset`  in  1  synchronous, active-high
- `rot`  in  1  one-cycle pulse: rotate clockwise
- `left`  in  1  one-cycle pulse: move x-1
- `right`  in  1  one-cycle pulse: move x+1
- `down`  in  1  one-cycle pulse: soft drop, y+1
- `tick`  in  1  one-cycle gravity pulse, y+1
- `spawn`  in  1  one-cycle pulse: load a new piece
- `check_req`  out  1  proposed move valid; held until `check_done`
- `prop_x`  out  X_W  proposed x
- `prop_y`  out  Y_W  proposed y
- `prop_rot`  out  2  proposed rotation
- `check_done`  in  1  checker result valid, sampled only in CHECK
- `check_ok`  in  1  proposed placement is free; qualified by `check_done`
- `piece_x`  out  X_W  committed x
- `piece_y`  out  Y_W  committed y
- `rotation`  out  2  committed rotation, 0..3
- `lock`  out  1  one-cycle pulse: piece landed
- `busy`  out  1  high whenever state is not IDLE

## Operation
- Pending flags: one per source (`tick`, `down`, `rot`, `left`, `right`).
  - A flag sets on its pulse and clears when its request is selected.
  - A repeat pulse while the flag is already set is merged, not counted.
- Selection priority in IDLE: `tick` > `down` > `rot` > `left` > `right`. `tick` and `down` together are merged into a single y+1 move and both flags clear.
- States and transitions:
  - WAIT_SPAWN: state after reset. Pending flags are held clear. On `spawn`: x=SPAWN_X, y=SPAWN_Y, rotation=0; go to IDLE.
  - IDLE: if any flag is set, select one and form the proposal, then go to CHECK.
  - IDLE pre-rejects without a check (request dropped, stays IDLE):
    - `left` at x=0
    - `right` at x=BOARD_W-1
  - IDLE, y+1 with y=BOARD_H-1: go straight to LOCK with no check.
  - CHECK: `check_req`=1 and `prop_*` held stable.
    - On `check_done` with `check_ok`=1: go to COMMIT.
    - On `check_done` with `check_ok`=0: a y+1 move goes to LOCK; any other move goes to IDLE and is dropped.
  - COMMIT: copy `prop_*` into `piece_*`/`rotation`; go to IDLE.
  - LOCK: `lock`=1 for this cycle only; clear all pending flags; go to WAIT_SPAWN.
- Rotation arithmetic is 2-bit modulo: 3 wraps to 0. Wall kicks are out of scope; the checker decides.
- Pulses that arrive in LOCK or WAIT_SPAWN are discarded, with one exception: `spawn` in WAIT_SPAWN.
- `spawn` in any other state is ignored.

## Timing
- Reset values:
  - state WAIT_SPAWN
  - `piece_x`=SPAWN_X, `piece_y`=SPAWN_Y, `rotation`=0
  - `prop_*` equal to the committed values
  - `check_req`=0, `lock`=0, `busy`=1
  - all pending flags cleared
- Reset mid-CHECK: `check_req` is low in the cycle after the reset edge, and a late `check_done` is ignored.
- Latency:
  - Request pulse at cycle N sets its flag at N+1.
  - The flag is selected at the N+1 edge if in IDLE, so `check_req` is high from N+2.
  - `check_done` seen at cycle M updates `piece_*` at M+2 (COMMIT takes one cycle).
- `check_done` may arrive in the first cycle `check_req` is high; minimum CHECK dwell is 1 cycle.
- A flag pulse arriving in the same cycle that flag is being cleared by selection re-sets the flag; no loss.
- Throughput: at most one committed move per 3 cycles.

## Structure
- Shared package `tetris_pkg`:
  - state enum {WAIT_SPAWN, IDLE, CHECK, COMMIT, LOCK}
  - move-kind enum {MV_DOWN, MV_ROT, MV_LEFT, MV_RIGHT}
  - BOARD_W/BOARD_H defaults
- Sub-module `move_req_latch`: pending flags plus the fixed-priority select, giving a one-hot pick and a `clear` input. The FSM and position registers stay in the top module.

## Test plan
- Reset then `spawn` -> x=4, y=0, rot=0, `busy`=0 two cycles later.
- `rot` four times, each with `check_ok`=1 -> rotation sequence 1,2,3,0; the 3->0 wrap is checked.
- `left` at x=0 -> `check_req` never asserts and x stays 0. `right` at x=9 -> same.
- `tick` and `left` in the same cycle -> first check is y+1 (`prop_y`=1, `prop_x`=4), then `prop_x`=3 with `prop_y`=1.
- `tick` with `check_ok`=0 at y=7 -> `lock` high exactly 1 cycle. A `rot` issued during WAIT_SPAWN is discarded, and the following `spawn` restores x=4, y=0.
- `reset` asserted while `check_req`=1 -> `check_req`=0 next cycle, state WAIT_SPAWN, a later `check_done` has no effect.
